// File: rtl/tf_quant_pkg.sv
// Shared widths and constants for the TF requantization stage.
// The optional fused-ReLU clamp is selected with the macro TF_REQUANT_RELU_EN.
package tf_quant_pkg;

  localparam int ACC_BIT_WIDTH          = 32;
  localparam int QUAN_SCALE_BIT_WIDTH   = 24;
  localparam int BIAS_BIT_WIDTH         = 32;
  localparam int MULT_BIT_WIDTH         = 16;
  localparam int SHIFT_BIT_WIDTH        = 5;
  localparam int NEURON_ACTIV_BIT_WIDTH = 8;
  localparam int CNT_BIT_WIDTH          = 16;

  localparam int ACT_MAX = 255;

  // Offset-corrected accumulator and full product widths.
  localparam int C_BIT_WIDTH = 34;
  localparam int P_BIT_WIDTH = 50;
  // Rounded/shifted value plus zero point; two guard bits keep the rounding add exact.
  localparam int R_BIT_WIDTH = P_BIT_WIDTH + 2;

endpackage

// File: rtl/tf_round_shift.sv
// Rounding arithmetic right shift (round half toward +inf) followed by the
// output zero-point add, registered once under the pipeline advance enable.
module tf_round_shift
  import tf_quant_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en_i,
  input  logic signed [P_BIT_WIDTH-1:0]       p_i,
  input  logic        [SHIFT_BIT_WIDTH-1:0]   shift_i,
  input  logic        [NEURON_ACTIV_BIT_WIDTH-1:0] zero_i,
  output logic signed [R_BIT_WIDTH-1:0]       r_o
);

  logic signed [R_BIT_WIDTH-1:0] p_ext;
  logic signed [R_BIT_WIDTH-1:0] rnd;
  logic signed [R_BIT_WIDTH-1:0] shifted;
  logic signed [R_BIT_WIDTH-1:0] zero_ext;
  logic signed [R_BIT_WIDTH-1:0] r_d;
  logic signed [R_BIT_WIDTH-1:0] r_q;

  // Rounding offset, arithmetic shift and zero-point add.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    p_ext    = R_BIT_WIDTH'(p_i);
    rnd      = '0;
    if (shift_i != '0) begin
      rnd = R_BIT_WIDTH'(1) <<< (shift_i - SHIFT_BIT_WIDTH'(1));
    end
    shifted  = (p_ext + rnd) >>> shift_i;
    zero_ext = R_BIT_WIDTH'(zero_i);
    r_d      = shifted + zero_ext;
  end

  // Stage-3 result register, held while the pipeline is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset too, so activation_o is 0 out of reset, not X.
    if (!rst_n) begin
      r_q <= '0;
    end else if (en_i) begin
      // NOTE: sequential state uses non-blocking assignment so all stages update together.
      r_q <= r_d;
    end
  end

  assign r_o = r_q;

endmodule

// File: rtl/tf_requantization.sv
// TF output requantization: bias add, offset correction, Q15 scale with
// rounding shift, zero-point add and 8-bit saturation in a 4-stage
// valid/ready pipeline with a global stall and a per-stage beat counter.
// Define TF_REQUANT_RELU_EN to clamp at the output zero point (fused ReLU).
module tf_requantization
  import tf_quant_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  layer_reset_n,
  input  logic                                  cfg_load_i,
  input  logic signed [MULT_BIT_WIDTH-1:0]      quan_mult_i,
  input  logic        [SHIFT_BIT_WIDTH-1:0]     quan_shift_i,
  input  logic        [NEURON_ACTIV_BIT_WIDTH-1:0] out_zero_i,
  input  logic        [CNT_BIT_WIDTH-1:0]       num_out_i,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  input  logic signed [ACC_BIT_WIDTH-1:0]       acc_i,
  input  logic signed [BIAS_BIT_WIDTH-1:0]      bias_i,
  input  logic        [QUAN_SCALE_BIT_WIDTH-1:0] quan_scale_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic        [NEURON_ACTIV_BIT_WIDTH-1:0] activation_o,
  output logic                                  out_last_o,
  output logic                                  busy_o
);

  logic adv;
  logic busy;
  logic cfg_take;
  logic last;

  logic v1_q, v2_q, v3_q, out_valid_q;

  logic signed [C_BIT_WIDTH-1:0] c_d, c_q;
  logic signed [P_BIT_WIDTH-1:0] p_d, p_q;
  logic signed [R_BIT_WIDTH-1:0] r_q;
  logic signed [R_BIT_WIDTH-1:0] lo_ext, hi_ext;
  logic [NEURON_ACTIV_BIT_WIDTH-1:0] lo;
  logic [NEURON_ACTIV_BIT_WIDTH-1:0] act_d, act_q;

  logic signed [MULT_BIT_WIDTH-1:0]      mult_q;
  logic        [SHIFT_BIT_WIDTH-1:0]     shift_q;
  logic        [NEURON_ACTIV_BIT_WIDTH-1:0] zero_q;
  logic        [CNT_BIT_WIDTH-1:0]       num_q;
  logic        [CNT_BIT_WIDTH-1:0]       cnt_d, cnt_q;

  // One stall signal for the whole pipeline; bubbles travel with the beats.
  assign adv        = ~out_valid_q | out_ready_i;
  assign in_ready_o = adv;
  assign busy       = v1_q | v2_q | v3_q | out_valid_q;
  assign busy_o     = busy;
  assign cfg_take   = cfg_load_i & ~busy;
  // num_q == 0 wraps num_q-1 to all ones, giving a 2^CNT_BIT_WIDTH-beat stage.
  assign last       = cnt_q == (num_q - CNT_BIT_WIDTH'(1));

  assign out_valid_o  = out_valid_q;
  assign activation_o = act_q;
  assign out_last_o   = out_valid_q & last;

`ifdef TF_REQUANT_RELU_EN
  assign lo = zero_q;
`else
  assign lo = '0;
`endif

  // S1 offset correction, S2 full product, S4 saturation and counter next state.
  always_comb begin
    c_d    = C_BIT_WIDTH'(acc_i) + C_BIT_WIDTH'(bias_i) - C_BIT_WIDTH'(quan_scale_i);
    p_d    = P_BIT_WIDTH'(c_q) * P_BIT_WIDTH'(mult_q);
    lo_ext = R_BIT_WIDTH'(lo);
    hi_ext = R_BIT_WIDTH'(ACT_MAX);
    act_d  = r_q[NEURON_ACTIV_BIT_WIDTH-1:0];
    if (r_q < lo_ext) begin
      act_d = lo;
    end else if (r_q > hi_ext) begin
      act_d = NEURON_ACTIV_BIT_WIDTH'(ACT_MAX);
    end
    cnt_d = cnt_q;
    if (cfg_take) begin
      cnt_d = '0;
    end else if (out_valid_q && out_ready_i) begin
      cnt_d = last ? '0 : cnt_q + CNT_BIT_WIDTH'(1);
    end
  end

  // Stage valid bits shift forward only when the pipeline advances.
  always_ff @(posedge clk or negedge layer_reset_n) begin
    if (!layer_reset_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (adv) begin
      v1_q        <= in_valid_i;
      v2_q        <= v1_q;
      v3_q        <= v2_q;
      out_valid_q <= v3_q;
    end
  end

  // Stage data registers, held stable during a stall.
  always_ff @(posedge clk or negedge layer_reset_n) begin
    if (!layer_reset_n) begin
      c_q   <= '0;
      p_q   <= '0;
      act_q <= '0;
    end else if (adv) begin
      c_q   <= c_d;
      p_q   <= p_d;
      act_q <= act_d;
    end
  end

  // Configuration loads only when the pipeline is empty; the beat counter restarts with it.
  always_ff @(posedge clk or negedge layer_reset_n) begin
    if (!layer_reset_n) begin
      mult_q  <= '0;
      shift_q <= '0;
      zero_q  <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (cfg_take) begin
        mult_q  <= quan_mult_i;
        shift_q <= quan_shift_i;
        zero_q  <= out_zero_i;
        num_q   <= num_out_i;
      end
    end
  end

  tf_round_shift u_round_shift (
    .clk     (clk),
    .rst_n   (layer_reset_n),
    .en_i    (adv),
    .p_i     (p_q),
    .shift_i (shift_q),
    .zero_i  (zero_q),
    .r_o     (r_q)
  );

endmodule

// File: tb/tb_tf_requantization.sv
// Self-checking bench for tf_requantization: a queue-based arithmetic model
// predicts every output beat; a negedge monitor compares on each cycle.
module tb_tf_requantization;

  logic               clk = 1'b0;
  logic               layer_reset_n;
  logic               cfg_load_i;
  logic signed [15:0] quan_mult_i;
  logic        [4:0]  quan_shift_i;
  logic        [7:0]  out_zero_i;
  logic        [15:0] num_out_i;
  logic               in_valid_i;
  logic               in_ready_o;
  logic signed [31:0] acc_i;
  logic signed [31:0] bias_i;
  logic        [23:0] quan_scale_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic        [7:0]  activation_o;
  logic               out_last_o;
  logic               busy_o;

  always #5 clk = ~clk;

  tf_requantization dut (
    .clk          (clk),
    .layer_reset_n(layer_reset_n),
    .cfg_load_i   (cfg_load_i),
    .quan_mult_i  (quan_mult_i),
    .quan_shift_i (quan_shift_i),
    .out_zero_i   (out_zero_i),
    .num_out_i    (num_out_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .acc_i        (acc_i),
    .bias_i       (bias_i),
    .quan_scale_i (quan_scale_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .activation_o (activation_o),
    .out_last_o   (out_last_o),
    .busy_o       (busy_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Requantization straight from the arithmetic definition, in 64-bit integers.
  function automatic int exp_act(input longint acc, input longint bias, input longint scale,
                                 input longint mult, input int shift, input int zp);
    longint c, p, r, lo;
    c = acc + bias - scale;
    p = c * mult;
    r = p;
    if (shift != 0) r = (p + (64'sd1 <<< (shift - 1))) >>> shift;
    r = r + zp;
`ifdef TF_REQUANT_RELU_EN
    lo = zp;
`else
    lo = 0;
`endif
    if (r < lo) r = lo;
    if (r > 255) r = 255;
    return int'(r);
  endfunction

  // Model state: configuration as the DUT should hold it, in-flight beats, beat counter.
  longint m_mult  = 0;
  int     m_shift = 0;
  int     m_zero  = 0;
  int     m_num   = 0;
  int     cnt_m   = 0;
  int     exp_q[$];
  int     last_log[$];
  int     n_out   = 0;
  bit     hold_valid = 1'b0;
  int     hold_act, hold_last;
  int     e;
  bit     exp_last;

  // Per-cycle compare against the model; handshakes seen here complete at the next rising edge.
  always @(negedge clk) begin
    if (!layer_reset_n) begin
      exp_q.delete();
      cnt_m = 0; m_mult = 0; m_shift = 0; m_zero = 0; m_num = 0;
      hold_valid = 1'b0;
      check("rst_out_valid", out_valid_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_last", out_last_o, 0);
    end else begin
      check("in_ready", in_ready_o, !out_valid_o || out_ready_i);
      check("busy", busy_o, exp_q.size() != 0);
      if (hold_valid) begin
        check("hold_valid", out_valid_o, 1);
        check("hold_act", activation_o, hold_act);
        check("hold_last", out_last_o, hold_last);
      end
      if (cfg_load_i && exp_q.size() == 0) begin
        m_mult = longint'(quan_mult_i); m_shift = int'(quan_shift_i);
        m_zero = int'(out_zero_i);      m_num   = int'(num_out_i);
        cnt_m  = 0;
      end
      if (out_valid_o) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          e        = exp_q[0];
          exp_last = (cnt_m == ((m_num - 1) & 16'hFFFF));
          check("activation", activation_o, e);
          check("out_last", out_last_o, exp_last);
          if (out_ready_i) begin
            void'(exp_q.pop_front());
            last_log.push_back(int'(out_last_o));
            n_out++;
            cnt_m = exp_last ? 0 : ((cnt_m + 1) & 16'hFFFF);
          end
        end
      end
      hold_valid = out_valid_o && !out_ready_i;
      hold_act   = int'(activation_o);
      hold_last  = int'(out_last_o);
      if (in_valid_i && in_ready_o)
        exp_q.push_back(exp_act(longint'(acc_i), longint'(bias_i), longint'(quan_scale_i),
                                m_mult, m_shift, m_zero));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    if ($urandom_range(0, 1) == 1) begin
      acc_i  = $urandom;
      bias_i = $urandom;
    end else begin
      acc_i  = 32'($urandom_range(0, 4000)) - 32'sd2000;
      bias_i = 32'($urandom_range(0, 400)) - 32'sd200;
    end
    quan_scale_i = 24'($urandom_range(0, 1) == 1 ? $urandom : $urandom_range(0, 300));
  endtask

  task automatic drain();
    int b = 0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    while (exp_q.size() != 0 && b < 200) begin
      tick();
      b++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  task automatic set_cfg(input int mult, input int shift, input int zp, input int num);
    drain();
    cfg_load_i   = 1'b1;
    quan_mult_i  = 16'(mult);
    quan_shift_i = 5'(shift);
    out_zero_i   = 8'(zp);
    num_out_i    = 16'(num);
    tick();
    cfg_load_i   = 1'b0;
  endtask

  // One beat into an empty pipeline: checks latency and a hand-computed value.
  task automatic single(input string name, input int acc, input int bias, input int scale,
                        input int expv);
    int k = 1;
    drain();
    in_valid_i   = 1'b1;
    acc_i        = acc;
    bias_i       = bias;
    quan_scale_i = 24'(scale);
    tick();
    in_valid_i   = 1'b0;
    while (!out_valid_o && k < 20) begin
      tick();
      k++;
    end
    check({name, "_latency"}, k, 4);
    check(name, activation_o, expv);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, c, out0, b;
    layer_reset_n = 1'b0;
    cfg_load_i = 1'b0; quan_mult_i = '0; quan_shift_i = '0; out_zero_i = '0; num_out_i = '0;
    in_valid_i = 1'b0; acc_i = '0; bias_i = '0; quan_scale_i = '0; out_ready_i = 1'b1;
    repeat (3) tick();
    check("rst_activation", activation_o, 0);
    check("rst_in_ready", in_ready_o, 1);
    layer_reset_n = 1'b1;
    tick();

    // Model pinned against hand-computed values.
    check("model_basic", exp_act(1000, 0, 200, 8192, 15, 3), 203);
    check("model_round_pos", exp_act(3, 0, 0, 1, 1, 0), 2);
    check("model_sat_hi", exp_act(800, 0, 0, 16384, 15, 10), 255);

    // Basic, rounding, saturation.
    set_cfg(8192, 15, 3, 16);
    single("basic", 1000, 0, 200, 203);
    set_cfg(1, 1, 0, 16);
    single("round_pos", 3, 0, 0, 2);
    single("round_neg", -3, 0, 0, 0);
    set_cfg(16384, 15, 10, 16);
    single("sat_hi", 800, 0, 0, 255);
`ifdef TF_REQUANT_RELU_EN
    single("sat_lo", -50, 0, 0, 10);
`else
    single("sat_lo", -50, 0, 0, 0);
`endif

    // Backpressure: 8 beats, consumer stalls for 5 cycles once outputs flow.
    set_cfg(8192, 13, 5, 0);
    sent = 0; c = 0; out0 = n_out;
    while ((sent < 8 || exp_q.size() != 0) && c < 60) begin
      out_ready_i = !(c >= 5 && c < 10);
      in_valid_i  = sent < 8;
      rand_data();
      #1;
      if (c >= 5 && c < 10) check("bp_in_ready", in_ready_o, 0);
      if (in_valid_i && in_ready_o) sent++;
      tick();
      c++;
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    check("bp_count", n_out - out0, 8);

    // Counter: num_out=3, 7 beats, plus a cfg load attempted while busy.
    set_cfg(8192, 15, 0, 3);
    last_log.delete();
    for (int i = 0; i < 7; i++) begin
      in_valid_i  = 1'b1;
      acc_i       = 32'(i * 1000);
      bias_i      = '0;
      quan_scale_i = '0;
      cfg_load_i  = (i == 3);
      quan_mult_i = (i == 3) ? 16'sd100 : 16'sd8192;
      #1;
      b = 0;
      while (!in_ready_o && b < 20) begin
        tick();
        b++;
      end
      tick();
    end
    cfg_load_i = 1'b0;
    quan_mult_i = 16'sd8192;
    drain();
    check("last_count", last_log.size(), 7);
    for (int i = 0; i < 7 && i < last_log.size(); i++)
      check($sformatf("last_beat_%0d", i + 1), last_log[i], (i == 2 || i == 5));

    // Reset with 3 beats in flight, then a fresh beat restarts the counter.
    set_cfg(8192, 15, 3, 1);
    in_valid_i = 1'b1;
    acc_i = 32'sd500; bias_i = '0; quan_scale_i = '0;
    repeat (3) tick();
    in_valid_i = 1'b0;
    layer_reset_n = 1'b0;
    tick();
    check("rst_mid_valid", out_valid_o, 0);
    check("rst_mid_busy", busy_o, 0);
    tick();
    layer_reset_n = 1'b1;
    tick();
    set_cfg(8192, 15, 3, 1);
    single("after_rst", 1000, 0, 200, 203);
    check("after_rst_last", out_last_o, 1);

    // Randomized traffic across several configurations.
    for (int r = 0; r < 4; r++) begin
      set_cfg(int'($urandom_range(0, 65535)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 9)));
      for (int k = 0; k < 200; k++) begin
        in_valid_i  = ($urandom_range(0, 9) < 6);
        out_ready_i = ($urandom_range(0, 9) < 7);
        cfg_load_i  = ($urandom_range(0, 19) == 0);
        quan_mult_i = 16'($urandom);
        rand_data();
        tick();
      end
      cfg_load_i = 1'b0;
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
